// File: rtl/blinker_pattern_player.sv
// blinker_pattern_player
//   Avalon-MM read master that walks an LED pattern table held in an on-chip
//   memory and drives the board LEDs. Each table word carries a hold time in
//   bits [DATA_W-1:8] and an LED pattern in bits [7:0]. A word whose hold
//   field is zero terminates the sequence, and playback loops back to the
//   latched start address. A sequence with no playable word sets a sticky
//   error flag and the player parks in IDLE.
//
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   enable              1 = play, 0 = stop and return to IDLE
//   pause               freezes the hold countdown only
//   start_addr          first table word, latched when leaving IDLE
//   avm_address         memory word address
//   avm_chipselect      one-cycle read strobe
//   avm_write           tied 0 (read-only master)
//   avm_byteenable      tied all-ones
//   avm_writedata       tied 0
//   avm_readdata        memory read data, valid RD_LAT cycles after the strobe
//   led                 current pattern
//   busy                1 whenever the player is not in IDLE
//   wrap_pulse          one-cycle pulse on each end-of-sequence loop
//   seq_err             sticky empty-sequence flag, cleared by enable=0
module blinker_pattern_player #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LED_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              pause,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [LED_W-1:0]  led,
  output logic              busy,
  output logic              wrap_pulse,
  output logic              seq_err
);

  localparam int HOLD_W = DATA_W - 8;
  // WAIT counts down from RD_LAT-1; capture happens when it reaches zero.
  localparam logic [1:0]        LAT_INIT = 2'(RD_LAT - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [1:0]          lat_q, lat_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic                wrap_q, wrap_d;
  logic                err_q, err_d;
  logic                seen_q, seen_d;
  logic                cs_q, cs_d;
  logic                busy_q, busy_d;
  logic [HOLD_W-1:0]   hold_field_s;
  logic [LED_W-1:0]    led_field_s;

  assign hold_field_s = avm_readdata[DATA_W-1:8];
  assign led_field_s  = avm_readdata[LED_W-1:0];

  // Next-state and next-output logic for the playback FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    start_d = start_q;
    hold_d  = hold_q;
    lat_d   = lat_q;
    led_d   = led_q;
    wrap_d  = 1'b0;
    err_d   = err_q;
    seen_d  = seen_q;

    if (!enable) begin
      // Stop wins over everything, including a capture or terminator
      // landing on the same edge; any read in flight is dropped.
      state_d = ST_IDLE;
      led_d   = {LED_W{1'b0}};
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!err_q) begin
            state_d = ST_FETCH;
            start_d = start_addr;
            addr_d  = start_addr;
            seen_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FETCH: begin
          state_d = ST_WAIT;
          lat_d   = LAT_INIT;
        end
        ST_WAIT: begin
          if (lat_q != 2'd0) begin
            lat_d = lat_q - 2'd1;
          end else if (hold_field_s != {HOLD_W{1'b0}}) begin
            led_d   = led_field_s;
            hold_d  = hold_field_s - HOLD_ONE;
            seen_d  = 1'b1;
            state_d = ST_HOLD;
          end else if (seen_q) begin
            // Terminator after at least one playable word: loop.
            addr_d  = start_q;
            wrap_d  = 1'b1;
            seen_d  = 1'b0;
            state_d = ST_FETCH;
          end else begin
            // Terminator with nothing playable since the last loop point.
            err_d   = 1'b1;
            led_d   = {LED_W{1'b0}};
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (pause) begin
            hold_d = hold_q;
          end else if (hold_q == {HOLD_W{1'b0}}) begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = ST_FETCH;
          end else begin
            hold_d = hold_q - HOLD_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Strobe and busy are registered from the next state so they line up
    // with the state they describe.
    cs_d   = (state_d == ST_FETCH);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      start_q <= {ADDR_W{1'b0}};
      hold_q  <= {HOLD_W{1'b0}};
      lat_q   <= 2'd0;
      led_q   <= {LED_W{1'b0}};
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      seen_q  <= 1'b0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      hold_q  <= hold_d;
      lat_q   <= lat_d;
      led_q   <= led_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write      = 1'b0;
  assign avm_byteenable = 4'hF;
  assign avm_writedata  = {DATA_W{1'b0}};
  assign led            = led_q;
  assign busy           = busy_q;
  assign wrap_pulse     = wrap_q;
  assign seq_err        = err_q;

endmodule

// File: tb/tb_blinker_pattern_player.sv
// Testbench for blinker_pattern_player. Two instances (read latency 1 and 3)
// share one pattern memory image; each has its own read pipeline. A reference
// model turns the table, the start address, the pause schedule and the stop
// edge into a list of timestamped visible events (led changes, wrap pulses,
// error rise, busy fall, fetch strobes) which a negedge monitor pops and
// compares as the DUTs present them.
module tb_blinker_pattern_player;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int LW   = 8;
  localparam int MAXE = 512;
  localparam int K_LED = 0, K_WRAP = 1, K_ERR = 2, K_IDLE = 3, K_FETCH = 4;

  typedef struct {int d; int kind; int val; int at;} ev_t;

  logic          clk;
  logic          reset_n;
  logic [1:0]    en_v, pause_v;
  logic [AW-1:0] start_v [2];
  logic [AW-1:0] addr_w  [2];
  logic [1:0]    cs_w, wr_w, busy_w, wrap_w, err_w;
  logic [3:0]    be_w    [2];
  logic [DW-1:0] wd_w    [2];
  logic [LW-1:0] led_w   [2];
  logic [DW-1:0] rd0, p1a, p1b, rd1;
  logic [DW-1:0] mem [0:4095];

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  bit  pause_at [MAXE];
  ev_t evq [$];

  blinker_pattern_player #(.ADDR_W(AW), .DATA_W(DW), .LED_W(LW), .RD_LAT(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .enable(en_v[0]), .pause(pause_v[0]),
    .start_addr(start_v[0]), .avm_address(addr_w[0]), .avm_chipselect(cs_w[0]),
    .avm_write(wr_w[0]), .avm_byteenable(be_w[0]), .avm_writedata(wd_w[0]),
    .avm_readdata(rd0), .led(led_w[0]), .busy(busy_w[0]),
    .wrap_pulse(wrap_w[0]), .seq_err(err_w[0]));

  blinker_pattern_player #(.ADDR_W(AW), .DATA_W(DW), .LED_W(LW), .RD_LAT(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .enable(en_v[1]), .pause(pause_v[1]),
    .start_addr(start_v[1]), .avm_address(addr_w[1]), .avm_chipselect(cs_w[1]),
    .avm_write(wr_w[1]), .avm_byteenable(be_w[1]), .avm_writedata(wd_w[1]),
    .avm_readdata(rd1), .led(led_w[1]), .busy(busy_w[1]),
    .wrap_pulse(wrap_w[1]), .seq_err(err_w[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory read pipelines; outside a read the bus carries junk.
  always @(posedge clk) rd0 <= cs_w[0] ? mem[addr_w[0]] : $urandom();
  always @(posedge clk) begin
    p1a <= cs_w[1] ? mem[addr_w[1]] : $urandom();
    p1b <= p1a;
    rd1 <= p1b;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic got(input int d, input int kind, input int val);
    ev_t e;
    n_tests++;
    if (evq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: dut%0d kind=%0d val=%0h at edge %0d, none expected",
               d, kind, val, cyc);
    end else begin
      e = evq.pop_front();
      if (e.d != d || e.kind != kind || e.val != val || e.at != cyc) begin
        n_fail++;
        $display("FAIL event: got dut%0d kind=%0d val=%0h edge=%0d, expected dut%0d kind=%0d val=%0h edge=%0d",
                 d, kind, val, cyc, e.d, e.kind, e.val, e.at);
      end
    end
  endtask

  // Monitor: turns visible output activity into events and scores them.
  logic [LW-1:0] led_p [2];
  logic [1:0]    busy_p = 2'b00, err_p = 2'b00;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mon_en) begin
        if (led_w[d] != led_p[d])      got(d, K_LED, int'(led_w[d]));
        if (wrap_w[d])                 got(d, K_WRAP, 0);
        if (err_w[d] && !err_p[d])     got(d, K_ERR, 1);
        if (!busy_w[d] && busy_p[d])   got(d, K_IDLE, 0);
        if (cs_w[d])                   got(d, K_FETCH, int'(addr_w[d]));
      end
      led_p[d]  <= led_w[d];
      busy_p[d] <= busy_w[d];
      err_p[d]  <= err_w[d];
    end
  end

  task automatic push(input int d, input int kind, input int val, input int at);
    ev_t e;
    e.d = d; e.kind = kind; e.val = val; e.at = at;
    evq.push_back(e);
  endtask

  // Reference model: edge numbers are relative to the first enabled edge.
  // A read issued at fetch edge f is consumed at edge f+1+L; a word with
  // hold H keeps its pattern for H unpaused edges before the next fetch.
  task automatic model(input int d, input int sa, input int stop, input int base);
    int L, f, c, e, a, h, v, cur, rem;
    bit seen;
    logic [DW-1:0] w;
    L = (d == 0) ? 1 : 3;
    a = sa; cur = 0; seen = 1'b0; f = 0;
    while (f < stop) begin
      push(d, K_FETCH, a, base + f);
      c = f + 1 + L;
      if (c >= stop) break;
      w = mem[a];
      h = int'(w[DW-1:8]);
      v = int'(w[7:0]);
      if (h != 0) begin
        seen = 1'b1;
        if (v != cur) push(d, K_LED, v, base + c);
        cur = v;
        rem = h; e = c;
        while (rem > 0 && e < stop) begin
          e++;
          if (!pause_at[e]) rem--;
        end
        a = (a + 1) % 4096;
        f = e;
      end else if (seen) begin
        push(d, K_WRAP, 0, base + c);
        seen = 1'b0;
        a = sa;
        f = c;
      end else begin
        if (cur != 0) push(d, K_LED, 0, base + c);
        push(d, K_ERR, 1, base + c);
        push(d, K_IDLE, 0, base + c);
        return;
      end
    end
    if (cur != 0) push(d, K_LED, 0, base + stop);
    push(d, K_IDLE, 0, base + stop);
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk($sformatf("%s_led_d%0d", tag, d),  int'(led_w[d]), 0);
    chk($sformatf("%s_busy_d%0d", tag, d), int'(busy_w[d]), 0);
    chk($sformatf("%s_cs_d%0d", tag, d),   int'(cs_w[d]), 0);
    chk($sformatf("%s_addr_d%0d", tag, d), int'(addr_w[d]), 0);
    chk($sformatf("%s_wrap_d%0d", tag, d), int'(wrap_w[d]), 0);
    chk($sformatf("%s_err_d%0d", tag, d),  int'(err_w[d]), 0);
  endtask

  task automatic clr_pause();
    for (int k = 0; k < MAXE; k++) pause_at[k] = 1'b0;
  endtask

  // Play one scenario on DUT d: enable on relative edge 0, drop enable on
  // edge 'stop'. rst_k >= 0 pulls reset on that relative edge instead.
  task automatic run_scn(input int d, input int sa, input int stop,
                         input bit exp_err, input int rst_k);
    int base;
    base = cyc + 1;
    model(d, sa, stop, base);
    start_v[d] = AW'(sa);
    for (int k = 0; k <= stop; k++) begin
      if (k == rst_k) begin
        @(negedge clk); #1;
        mon_en = 1'b0; reset_n = 1'b0; en_v = 2'b00;
        @(posedge clk); #1;
        chk_zero(d, "midrst");
        reset_n = 1'b1;
        evq.delete();
        @(negedge clk); #1;
        mon_en = 1'b1;
        return;
      end
      en_v[d]    = (k < stop);
      pause_v[d] = pause_at[k];
      if (exp_err && k == stop) begin
        chk($sformatf("empty_err_d%0d", d),  int'(err_w[d]), 1);
        chk($sformatf("empty_busy_d%0d", d), int'(busy_w[d]), 0);
      end
      @(posedge clk); #1;
    end
    pause_v[d] = 1'b0;
    chk($sformatf("stop_err_clear_d%0d", d), int'(err_w[d]), 0);
    chk($sformatf("stop_busy_d%0d", d), int'(busy_w[d]), 0);
    repeat (6) @(posedge clk);
    #1;
    chk($sformatf("drain_d%0d", d), evq.size(), 0);
    evq.delete();
  endtask

  task automatic load_basic();
    mem[0] = 32'h0000_03A5;
    mem[1] = 32'h0000_023C;
    mem[2] = 32'h0000_0000;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sa, stop, lat;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    clr_pause();
    reset_n = 1'b0; en_v = 2'b00; pause_v = 2'b00;
    start_v[0] = '0; start_v[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk_zero(d, "reset");
      chk($sformatf("write_d%0d", d), int'(wr_w[d]), 0);
      chk($sformatf("byteen_d%0d", d), int'(be_w[d]), 15);
      chk($sformatf("wdata_d%0d", d), int'(wd_w[d]), 0);
    end
    reset_n = 1'b1;
    @(negedge clk); #1;
    mon_en = 1'b1;

    // Basic playback on both latencies.
    load_basic();
    run_scn(0, 0, 40, 1'b0, -1);
    run_scn(1, 0, 45, 1'b0, -1);

    // Empty table.
    mem[5] = 32'h0;
    run_scn(0, 5, 12, 1'b1, -1);
    run_scn(1, 5, 14, 1'b1, -1);

    // Stop on capture edges, including a terminator capture.
    run_scn(0, 0, 7, 1'b0, -1);
    run_scn(0, 0, 11, 1'b0, -1);
    run_scn(1, 0, 11, 1'b0, -1);
    run_scn(1, 0, 17, 1'b0, -1);

    // Pause: 7 frozen HOLD edges plus pause during FETCH/WAIT.
    mem[10] = 32'h0000_0A11;
    mem[11] = 32'h0000_0322;
    mem[12] = 32'h0;
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      clr_pause();
      pause_at[1] = 1'b1;
      pause_at[1 + lat] = 1'b1;
      for (int k = 3 + lat; k <= 9 + lat; k++) pause_at[k] = 1'b1;
      run_scn(d, 10, 60, 1'b0, -1);
    end
    clr_pause();

    // Address wrap 4095 -> 0 -> 1 -> 4095.
    mem[4095] = 32'h0000_010F;
    mem[0]    = 32'h0000_01F0;
    mem[1]    = 32'h0;
    run_scn(0, 4095, 30, 1'b0, -1);
    run_scn(1, 4095, 30, 1'b0, -1);

    // Largest hold value.
    mem[100] = 32'hFFFF_FF5A;
    run_scn(0, 100, 80, 1'b0, -1);

    // Reset mid-HOLD and reset on a capture edge.
    load_basic();
    run_scn(1, 0, 6, 1'b0, 6);
    run_scn(0, 0, 7, 1'b0, 7);

    // Randomized tables and pause schedules.
    for (int it = 0; it < 10; it++) begin
      sa = $urandom_range(0, 4095);
      n  = $urandom_range(0, 5);
      for (int j = 0; j < n; j++)
        mem[(sa + j) % 4096] = {24'($urandom_range(1, 5)), 8'($urandom_range(0, 255))};
      mem[(sa + n) % 4096] = 32'h0;
      for (int k = 0; k < MAXE; k++) pause_at[k] = ($urandom_range(0, 3) == 0);
      stop = $urandom_range(20, 200);
      run_scn(it % 2, sa, stop, (n == 0), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/blinker_pattern_player.md
Name: blinker_pattern_player

Overview:
- Avalon-MM read master sitting directly upstream of the blinker on-chip memory (4096 x 32, single port, 1-cycle read latency).
- Walks a pattern table stored in that memory and drives the board LEDs.
- Each table word holds an LED pattern and a hold time. A zero hold time marks end of sequence, and the player loops back to the start.

Parameters:
- ADDR_W, 12, word-address width of the memory port.
- DATA_W, 32, memory data width; word layout is [DATA_W-1:8] = hold cycles, [7:0] = LED pattern.
- LED_W, 8, LED output width (≤ 8).
- RD_LAT, 1, memory read latency in cycles, legal range 1..3.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- enable  in  1  level; 1 = play, 0 = stop and return to IDLE.
- pause  in  1  level; freezes the hold countdown only.
- start_addr  in  ADDR_W  first table word; latched on leaving IDLE.
- avm_address  out  ADDR_W  memory word address.
- avm_chipselect  out  1  read strobe; memory write is never asserted.
- avm_write  out  1  constant 0.
- avm_byteenable  out  4  constant 4'hF.
- avm_writedata  out  DATA_W  constant 0.
- avm_readdata  in  DATA_W  memory read data.
- led  out  LED_W  current pattern.
- busy  out  1  1 whenever state ≠ IDLE.
- wrap_pulse  out  1  one-cycle pulse on each end-of-sequence loop.
- seq_err  out  1  sticky flag: empty sequence detected.

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE; led=0, avm_address=0, avm_chipselect=0, busy=0, wrap_pulse=0, seq_err=0; hold counter=0 and latched start=0.
- States: IDLE, FETCH, WAIT, HOLD.
- IDLE:
  - With enable=1 and seq_err=0: latch start_addr into start_reg and into the address register, go to FETCH.
  - seq_err clears only on enable=0 or reset.
- FETCH (one cycle): avm_chipselect=1 with avm_address=current address; go to WAIT with the latency counter loaded to RD_LAT-1.
- WAIT:
  - avm_chipselect=0; lasts exactly RD_LAT cycles.
  - On the final WAIT edge, avm_readdata is captured and decoded.
- Decode, hold field H ≠ 0:
  - led ← readdata[LED_W-1:0] and the hold counter ← H-1; go to HOLD.
  - The current address is recorded as "sequence non-empty".
- Decode, H = 0 (terminator):
  - led unchanged; address ← start_reg.
  - wrap_pulse=1 for the following cycle.
  - Go to FETCH.
  - If no H≠0 word was seen since leaving IDLE or since the last wrap: set seq_err=1, go to IDLE, and do not assert wrap_pulse.
- HOLD:
  - If pause=1, the counter holds.
  - Otherwise, if counter=0: address ← address+1 (modulo 2^ADDR_W, so 4095→0), go to FETCH.
  - Otherwise decrement.
- Timing: with pause=0, consecutive led updates are exactly H+1+RD_LAT cycles apart (H+2 for the default).
- Hold width: the hold field is 24 bits, unsigned; the largest value, 2^24-1, must not overflow the counter.
- enable=0 in any non-IDLE state: at the next edge go to IDLE; avm_chipselect=0, led=0, busy=0. Any read in flight is discarded.
- pause during FETCH/WAIT: no effect; the read completes and led updates on schedule, then HOLD is frozen.
- reset_n=0 mid-operation overrides everything, including a capture on the same edge.
- enable and a terminator on the same edge: enable=0 wins (go to IDLE, no wrap_pulse).

Test Plan:
- Basic playback:
  - Stimulus: memory model RD_LAT=1; words [0]=0x000003_A5, [1]=0x000002_3C, [2]=0; start_addr=0; enable=1.
  - Response: led=A5 for 5 cycles, then 3C for 4 cycles, then wrap_pulse one cycle; A5 reappears 2 cycles after the terminator capture.
- Empty table:
  - Stimulus: [5]=0; start_addr=5; enable=1.
  - Response: after FETCH+WAIT, seq_err=1, busy=0, led=0, no wrap_pulse. seq_err clears one edge after enable=0.
- Pause:
  - Stimulus: during HOLD of word H=10, pause=1 for 7 cycles.
  - Response: next led update is delayed by exactly 7 cycles; with pause asserted during WAIT, the led still updates on schedule.
- Stop mid-read:
  - Stimulus: enable=0 on the WAIT cycle.
  - Response: next edge gives IDLE, led=0, chipselect=0; a stale readdata is never shown.
- Address wrap:
  - Stimulus: start_addr=4095; [4095]=0x000001_0F, [0]=0x000001_F0, [1]=0.
  - Response: avm_address sequence 4095→0→1→4095; led toggles 0F/F0.
- Latency:
  - Stimulus: RD_LAT=3 with the basic-playback table.
  - Response: led update spacing is H+4 cycles; capture happens on the 3rd WAIT edge; reset_n=0 mid-HOLD restores all reset values on that edge.
